empu_reset_ctrl: RTL
====================

EMPU_RESET_CTRL -- requirements
Module: empu_reset_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024: cycles mcu_reset_n stays low after all reset causes clear; legal range 2..65535.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a change on key_n; legal range 2..2^20.
REQ-003 Parameter WDOG_TIMEOUT, default 16777216: cycles without a kick edge before a watchdog reset; legal range 4..2^24.
REQ-004 sys_clk  input  1  MCU system clock, 200 MHz max; the PLL output that also clocks the EMPU.
REQ-005 reset_n  input  1  asynchronous active-low reset for this block.
REQ-006 pll_lock  input  1  PLL lock indicator, asynchronous.
REQ-007 key_n  input  1  push-button, active-low, asynchronous, bouncing.
REQ-008 wdog_kick  input  1  watchdog kick from an EMPU GPIO, asynchronous; any edge is a kick.
REQ-009 mcu_reset_n  output  1  registered active-low reset to the EMPU reset_n port.
REQ-010 rst_cause  output  2  cause of the last reset: 00 power-on/reset_n, 01 key, 10 lock loss, 11 watchdog.
REQ-011 rst_count  output  8  count of resets issued from RUN, saturating.

Function
REQ-012 Each of pll_lock, key_n and wdog_kick SHALL pass through its own 2-flop synchronizer; reset values are 0, 1 and 0.
REQ-013 States SHALL be WAIT_LOCK, HOLD and RUN; mcu_reset_n SHALL be 1 only in RUN and SHALL be driven from a flop.
REQ-014 WAIT_LOCK: stay while synced lock = 0; go to HOLD with hold counter = 0 when synced lock = 1.
REQ-015 HOLD: count up each cycle; go to WAIT_LOCK if synced lock = 0; go to RUN on the edge where count = HOLD_CYCLES-1.
REQ-016 Latency: count the edge that first samples pll_lock high as edge 1; HOLD SHALL be entered at edge 3 and mcu_reset_n SHALL rise at edge 3+HOLD_CYCLES.
REQ-017 RUN, lock loss: synced lock = 0 SHALL give WAIT_LOCK with rst_cause = 10.
REQ-018 RUN, key: a debounced press SHALL give HOLD with rst_cause = 01.
REQ-019 RUN, watchdog: a watchdog timeout SHALL give HOLD with rst_cause = 11.
REQ-020 RUN, simultaneous events: priority SHALL be lock loss > key > watchdog.
REQ-021 mcu_reset_n SHALL fall on the same edge that leaves RUN.
REQ-022 rst_count SHALL increment on every exit from RUN and hold at 255.
REQ-023 Debounce, accept: the synced key level SHALL be accepted only after it differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
REQ-024 Debounce, abort: any return to the accepted level SHALL clear the debounce counter.
REQ-025 Debounce, press event: a press event SHALL be a single-cycle pulse when the accepted level changes 1->0.
REQ-026 Debounce, held key: no further event SHALL occur until a release is accepted, so a held key causes exactly one reset.
REQ-027 Debounce, outside RUN: the debouncer SHALL run in all states; a press event outside RUN SHALL be discarded.

Reset
REQ-028 While reset_n = 0, state SHALL be WAIT_LOCK and mcu_reset_n SHALL be 0.
REQ-029 While reset_n = 0, rst_cause, rst_count, and the hold, debounce and watchdog counters SHALL all be 0.
REQ-030 While reset_n = 0, the accepted key level SHALL be 1 and the synchronizers SHALL take their REQ-012 values.
REQ-031 Assertion of reset_n SHALL act immediately, including mid-HOLD or mid-RUN.
REQ-032 Deassertion of reset_n SHALL be synchronized to sys_clk with a 2-flop reset synchronizer before internal use.

Configuration
REQ-033 Macro EMPU_RESET_CTRL_WDOG_EN compiled in: the watchdog SHALL arm at the first synced kick edge in RUN.
REQ-034 With the macro, once armed, the watchdog counter SHALL clear on every kick edge and count every other RUN cycle.
REQ-035 With the macro, timeout SHALL fire when the count reaches WDOG_TIMEOUT-1.
REQ-036 With the macro, the watchdog SHALL disarm and clear whenever RUN is exited.
REQ-037 Macro absent: the watchdog logic and its synchronizer SHALL be omitted, wdog_kick SHALL be ignored, and rst_cause 11 SHALL never occur.

Verification (HOLD_CYCLES=16, DEBOUNCE_CYCLES=8, WDOG_TIMEOUT=64)
REQ-038 Power-up: release reset_n, raise pll_lock -> mcu_reset_n rises at edge 19 after lock is first sampled; rst_cause=00, rst_count=0.
REQ-039 Key bounce: key_n toggles every 3 cycles for 30 cycles, then stays low 8 cycles -> exactly one reset of 16 cycles; rst_cause=01, rst_count=1.
REQ-040 Lock loss mid-HOLD and in RUN: drop pll_lock at hold count 5 -> back to WAIT_LOCK, mcu_reset_n stays 0; drop it in RUN -> mcu_reset_n falls, rst_cause=10.
REQ-041 Watchdog (macro defined): one kick in RUN, then none for 64 cycles -> mcu_reset_n falls, rst_cause=11; kicks every 50 cycles -> no reset.
REQ-042 Collision and saturation: key press and lock loss in the same cycle -> rst_cause=10; 300 key resets -> rst_count=255.

Source files
------------

// File: rtl/empu_reset_ctrl.sv
// empu_reset_ctrl -- reset sequencer for the EMPU core.
//
// The EMPU is held in reset until the PLL has locked and then for a further
// HOLD_CYCLES cycles. Once it is running, it can be reset again in three ways:
// by loss of PLL lock, by a debounced push-button press, or by a watchdog
// timeout. The watchdog is built only when EMPU_RESET_CTRL_WDOG_EN is defined.
// Without that macro, wdog_kick is ignored and rst_cause never reads 11.
//
// Ports
//   sys_clk      in   MCU system clock (the PLL output that also clocks the EMPU)
//   reset_n      in   asynchronous active-low reset; deassertion is synchronised
//   pll_lock     in   PLL lock indicator, asynchronous
//   key_n        in   push-button, active-low, asynchronous, bouncing
//   wdog_kick    in   watchdog kick, asynchronous; either edge counts as a kick
//   mcu_reset_n  out  registered active-low reset to the EMPU; high only in RUN
//   rst_cause    out  cause of the last reset: 00 por, 01 key, 10 lock, 11 wdog
//   rst_count    out  number of exits from RUN, saturating at 255
//   fsm_state    out  current sequencer state (00 WAIT_LOCK, 01 HOLD, 10 RUN)
module empu_reset_ctrl #(
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int WDOG_TIMEOUT    = 16777216
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       key_n,
  input  logic       wdog_kick,
  output logic       mcu_reset_n,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count,
  output logic [1:0] fsm_state
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Reset assertion takes effect at once. Deassertion is released through
  // two flops, so every internal flop leaves reset on the same clean edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Input synchronisers
  logic [1:0] lock_sync;
  logic [1:0] key_sync;
  logic       lock_s;
  logic       key_s;

  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      lock_sync <= 2'b00;
      key_sync  <= 2'b11;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
      key_sync  <= {key_sync[0], key_n};
    end
  end

  assign lock_s = lock_sync[1];
  assign key_s  = key_sync[1];

  // Key debouncer. A new level is accepted only after it has differed from
  // the accepted level for DEBOUNCE_CYCLES consecutive cycles. Any bounce back
  // to the accepted level restarts the count. The debouncer runs in every
  // state, so a key held through a reset produces only one press event.
  logic             key_acc;
  logic [DEB_W-1:0] db_cnt;
  logic             key_accept;
  logic             key_press;

  assign key_accept = (key_s != key_acc) && (db_cnt == DEB_MAX);
  assign key_press  = key_accept && !key_s;

  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      key_acc <= 1'b1;
      db_cnt  <= '0;
    end else if (key_s == key_acc) begin
      db_cnt  <= '0;
    end else if (key_accept) begin
      key_acc <= key_s;
      db_cnt  <= '0;
    end else begin
      db_cnt  <= db_cnt + DEB_W'(1);
    end
  end

  // Sequencer
  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic [1:0]        cause_next;
  logic              count_inc;
  logic              wdog_timeout;

`ifdef EMPU_RESET_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_TIMEOUT - 1);

  // Bits [1:0] form the synchroniser. Bit [2] is the previous synced value,
  // used only for edge detection.
  logic [2:0]        kick_sync;
  logic              kick_edge;
  logic              wdog_armed;
  logic [WDOG_W-1:0] wdog_cnt;

  assign kick_edge    = kick_sync[2] ^ kick_sync[1];
  assign wdog_timeout = (state == RUN) && wdog_armed && !kick_edge &&
                        (wdog_cnt == WDOG_MAX);

  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) kick_sync <= 3'b000;
    else            kick_sync <= {kick_sync[1:0], wdog_kick};
  end

  // Only a cycle that is in RUN and stays in RUN can arm the watchdog or
  // advance its count. Any exit from RUN clears it.
  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wdog_armed <= 1'b0;
      wdog_cnt   <= '0;
    end else if ((state != RUN) || (state_next != RUN)) begin
      wdog_armed <= 1'b0;
      wdog_cnt   <= '0;
    end else if (kick_edge) begin
      wdog_armed <= 1'b1;
      wdog_cnt   <= '0;
    end else if (wdog_armed) begin
      wdog_cnt   <= wdog_cnt + WDOG_W'(1);
    end
  end
`else
  localparam int unused_wdog_timeout = WDOG_TIMEOUT;
  logic unused_kick;

  assign unused_kick  = wdog_kick;
  assign wdog_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    cause_next = rst_cause;
    count_inc  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = HOLD;
          hold_next  = '0;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          hold_next  = '0;
        end else if (hold_cnt == HOLD_MAX) begin
          state_next = RUN;
          hold_next  = '0;
        end else begin
          hold_next  = hold_cnt + HOLD_W'(1);
        end
      end
      RUN: begin
        // Priority when several causes coincide: lock loss > key > watchdog.
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cause_next = 2'b10;
          count_inc  = 1'b1;
        end else if (key_press) begin
          state_next = HOLD;
          hold_next  = '0;
          cause_next = 2'b01;
          count_inc  = 1'b1;
        end else if (wdog_timeout) begin
          state_next = HOLD;
          hold_next  = '0;
          cause_next = 2'b11;
          count_inc  = 1'b1;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      rst_cause   <= 2'b00;
      rst_count   <= 8'd0;
      mcu_reset_n <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      rst_cause   <= cause_next;
      if (count_inc && (rst_count != 8'hFF)) rst_count <= rst_count + 8'd1;
      // Taking the registered output from the next state makes it change on
      // the same edge as the state itself.
      mcu_reset_n <= (state_next == RUN);
    end
  end

  assign fsm_state = state;

endmodule
